// File: rtl/bec_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bec_bridge_pkg
// Description : Shared constants for the LA-to-BEC operand bridge: command
//               opcodes, FSM state encoding (which doubles as the status code
//               reported on la_data_out[127:124]) and the chunk-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package bec_bridge_pkg;

    // Command opcodes carried in la_data_in[31:24]
    localparam logic [7:0] c_OP_NOP   = 8'h00;
    localparam logic [7:0] c_OP_WRITE = 8'hA1;
    localparam logic [7:0] c_OP_START = 8'hA2;
    localparam logic [7:0] c_OP_READ  = 8'hA3;
    localparam logic [7:0] c_OP_ABORT = 8'hAF;

    // FSM states; the encoding is the status nibble seen by the host
    localparam logic [3:0] c_ST_IDLE  = 4'h1;
    localparam logic [3:0] c_ST_LOAD  = 4'h2;
    localparam logic [3:0] c_ST_BUSY  = 4'h9;
    localparam logic [3:0] c_ST_READY = 4'hC;

    // Status reported after a watchdog expiry (state itself is IDLE)
    localparam logic [3:0] c_STAT_TIMEOUT = 4'hF;

    // Number of CHUNK_W-bit transfers needed to cover one operand
    function automatic int calc_nch(input int op_w, input int chunk_w);
        return (op_w + chunk_w - 1) / chunk_w;
    endfunction

endpackage : bec_bridge_pkg
`default_nettype wire

// File: rtl/bec_bridge_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : bec_bridge_watchdog
// Description : Saturating cycle counter. Cleared by i_clr, advances while
//               i_en is high, and flags o_expired on the TIMEOUT_CYC-th
//               enabled cycle after a clear.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               i_clr     - restart the count (priority over i_en)
//               i_en      - count this cycle
//               o_expired - limit reached in this enabled cycle
// Revision    : 1.0 - initial release
// ============================================================================
module bec_bridge_watchdog #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int              c_CW   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT_CYC - 1);

    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    assign o_expired = i_en && (r_cnt == c_LAST);

endmodule : bec_bridge_watchdog
`default_nettype wire

// File: rtl/bec_la_operand_bridge.sv
`default_nettype none
// ============================================================================
// Module      : bec_la_operand_bridge
// Description : Logic-analyser to BEC-core operand bridge. The host streams
//               operands in CHUNK_W-bit chunks using toggle-sequenced commands,
//               starts the core, and reads results back chunk by chunk.
//               Optional BUSY watchdog enabled by macro BEC_BRIDGE_TIMEOUT_EN.
// Ports       : wb_clk_i    - clock
//               wb_rst_ni   - asynchronous active-low reset
//               la_data_in  - [31:24] opcode, [23:19] reg, [18:16] chunk,
//                             [15] seq, [127:32] payload
//               la_oenb     - command qualifies only when [31:15] are all 0
//               la_data_out - [127:124] status, [123] seq echo, [122] err,
//                             [95:0] read data
//               core_start  - one-cycle start pulse
//               core_abort  - one-cycle abort pulse
//               core_ops    - operand registers, reg i at [i*OP_WIDTH +: OP_WIDTH]
//               core_done   - completion pulse from the core
//               core_result - results, captured on core_done while BUSY
// Revision    : 1.0 - initial release
// ============================================================================
module bec_la_operand_bridge #(
    parameter int OP_WIDTH    = 163,
    parameter int CHUNK_W     = 82,
    parameter int NUM_REGS    = 7,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    input  logic [127:0]                 la_data_in,
    input  logic [127:0]                 la_oenb,
    output logic [127:0]                 la_data_out,
    output logic                         core_start,
    output logic                         core_abort,
    output logic [NUM_REGS*OP_WIDTH-1:0] core_ops,
    input  logic                         core_done,
    input  logic [NUM_REGS*OP_WIDTH-1:0] core_result
);
    import bec_bridge_pkg::*;

    localparam int c_NCH = calc_nch(OP_WIDTH, CHUNK_W);
    localparam int c_TOT = NUM_REGS * OP_WIDTH;
    localparam int c_NSL = NUM_REGS * c_NCH;

    // ------------------------------------------------------------------ regs
    logic [3:0]       r_state;
    logic             r_last_seq;
    logic             r_err;
    logic             r_to_flag;
    logic [3:0]       r_status;
    logic [95:0]      r_rdata;
    logic             r_start;
    logic             r_abort;
    logic [c_TOT-1:0] r_ops;

    // ---------------------------------------------------------------- decode
    logic [7:0]  w_op;
    logic [4:0]  w_rsel;
    logic [2:0]  w_csel;
    logic        w_seq;
    logic        w_accept;
    logic        w_range_ok;
    logic        w_legal;
    logic        w_do_write;
    logic        w_do_start;
    logic        w_do_read;
    logic        w_do_abort;
    logic        w_expired;
    logic        w_to_fire;
    logic        w_unused;

    assign w_op     = la_data_in[31:24];
    assign w_rsel   = la_data_in[23:19];
    assign w_csel   = la_data_in[18:16];
    assign w_seq    = la_data_in[15];
    // A new command is signalled only by the seq bit differing from the last
    // accepted one, so a held command is never executed twice.
    assign w_accept = (la_oenb[31:15] == '0) && (w_seq != r_last_seq);

    assign w_range_ok = (int'(w_rsel) < NUM_REGS) && (int'(w_csel) < c_NCH);

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_OP_NOP:   w_legal = 1'b1;
            c_OP_WRITE: w_legal = w_range_ok && (r_state != c_ST_BUSY);
            c_OP_START: w_legal = (r_state == c_ST_LOAD) || (r_state == c_ST_READY);
            c_OP_READ:  w_legal = w_range_ok &&
                                  ((r_state == c_ST_IDLE) || (r_state == c_ST_READY));
            c_OP_ABORT: w_legal = 1'b1;
            default:    w_legal = 1'b0;
        endcase
    end

    assign w_do_write = w_accept && w_legal && (w_op == c_OP_WRITE);
    assign w_do_start = w_accept && w_legal && (w_op == c_OP_START);
    assign w_do_read  = w_accept && w_legal && (w_op == c_OP_READ);
    assign w_do_abort = w_accept && (w_op == c_OP_ABORT);

    assign w_unused = ^{la_oenb[127:32], la_oenb[14:0], la_data_in[127:32], la_data_in[14:0]};

    // ---------------------------------------------- register file and readback
    logic [c_TOT-1:0]              w_ops_wr;
    logic [c_NSL:0][CHUNK_W-1:0]   w_rd_chain;
    logic [95:0]                   w_rd_data;

    assign w_rd_chain[0] = '0;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam logic [4:0] c_RI = 5'(i);
        for (genvar j = 0; j < c_NCH; j++) begin : g_chunk
            localparam int c_LO  = i * OP_WIDTH + j * CHUNK_W;
            // The last chunk of an operand may be short; extra payload is dropped.
            localparam int c_W   = (OP_WIDTH - j * CHUNK_W < CHUNK_W) ?
                                   (OP_WIDTH - j * CHUNK_W) : CHUNK_W;
            localparam int c_K   = i * c_NCH + j;
            logic               w_addr_hit;
            logic [CHUNK_W-1:0] w_chunk;

            // Chunks beyond the 3-bit chunk field can never be addressed.
            if (j < 8) begin : g_addr
                localparam logic [2:0] c_CJ = 3'(j);
                assign w_addr_hit = (w_rsel == c_RI) && (w_csel == c_CJ);
            end else begin : g_noaddr
                assign w_addr_hit = 1'b0;
            end

            assign w_ops_wr[c_LO +: c_W] = (w_do_write && w_addr_hit) ?
                                           la_data_in[32 +: c_W] : r_ops[c_LO +: c_W];

            if (c_W == CHUNK_W) begin : g_full
                assign w_chunk = r_ops[c_LO +: c_W];
            end else begin : g_short
                assign w_chunk = {{(CHUNK_W - c_W){1'b0}}, r_ops[c_LO +: c_W]};
            end

            // One-hot OR chain forms the read mux without variable indexing.
            assign w_rd_chain[c_K + 1] = w_rd_chain[c_K] | (w_addr_hit ? w_chunk : '0);
        end
    end

    if (CHUNK_W == 96) begin : g_rd_full
        assign w_rd_data = w_rd_chain[c_NSL];
    end else begin : g_rd_pad
        assign w_rd_data = {{(96 - CHUNK_W){1'b0}}, w_rd_chain[c_NSL]};
    end

    // -------------------------------------------------------------- watchdog
`ifdef BEC_BRIDGE_TIMEOUT_EN
    logic w_busy_entry;
    logic w_busy;
    assign w_busy       = (r_state == c_ST_BUSY);
    assign w_busy_entry = w_do_start;

    bec_bridge_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .i_clr     (w_busy_entry),
        .i_en      (w_busy),
        .o_expired (w_expired)
    );
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYC > 0);
    assign w_expired   = 1'b0;
`endif

    // Timeout only fires if neither a result nor an abort claims this cycle.
    assign w_to_fire = (r_state == c_ST_BUSY) && w_expired && !core_done && !w_do_abort;

    // ------------------------------------------------------------------- FSM
    logic [3:0] w_state_nxt;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_do_write) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:  if (w_do_start) w_state_nxt = c_ST_BUSY;
            c_ST_BUSY: begin
                if (core_done)      w_state_nxt = c_ST_READY;
                else if (w_expired) w_state_nxt = c_ST_IDLE;
            end
            c_ST_READY: begin
                if (w_do_write)      w_state_nxt = c_ST_LOAD;
                else if (w_do_start) w_state_nxt = c_ST_BUSY;
            end
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        if (w_do_abort) w_state_nxt = c_ST_IDLE;
    end

    logic        w_load;
    logic        w_abort_nxt;
    logic        w_err_nxt;
    logic        w_to_flag_nxt;
    logic [3:0]  w_status_nxt;
    logic [95:0] w_rdata_nxt;

    always_comb begin
        w_load      = (r_state == c_ST_BUSY) && core_done && !w_do_abort;
        w_abort_nxt = (r_state == c_ST_BUSY) && (w_do_abort || w_to_fire);

        w_err_nxt = r_err;
        if (w_accept)  w_err_nxt = !w_legal;
        if (w_to_fire) w_err_nxt = 1'b1;

        // Status F sticks until the host issues its next accepted command.
        w_to_flag_nxt = r_to_flag;
        if (w_accept)  w_to_flag_nxt = 1'b0;
        if (w_to_fire) w_to_flag_nxt = 1'b1;

        w_status_nxt = w_to_flag_nxt ? c_STAT_TIMEOUT : w_state_nxt;

        w_rdata_nxt = r_rdata;
        if (w_do_read) w_rdata_nxt = w_rd_data;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_last_seq <= 1'b0;
            r_err      <= 1'b0;
            r_to_flag  <= 1'b0;
            r_status   <= 4'h0;
            r_rdata    <= '0;
            r_start    <= 1'b0;
            r_abort    <= 1'b0;
            r_ops      <= '0;
        end else begin
            if (w_accept) r_last_seq <= w_seq;
            r_err     <= w_err_nxt;
            r_to_flag <= w_to_flag_nxt;
            r_status  <= w_status_nxt;
            r_rdata   <= w_rdata_nxt;
            r_start   <= w_do_start;
            r_abort   <= w_abort_nxt;
            r_ops     <= w_load ? core_result : w_ops_wr;
        end
    end

    assign la_data_out = {r_status, r_last_seq, r_err, 26'b0, r_rdata};
    assign core_start  = r_start;
    assign core_abort  = r_abort;
    assign core_ops    = r_ops;

endmodule : bec_la_operand_bridge
`default_nettype wire

// File: tb/tb_bec_la_operand_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_bec_la_operand_bridge
// Description : Directed self-checking bench for bec_la_operand_bridge with a
//               scoreboard queue of expected la_data_out words and a behavioural
//               model of the register file, FSM and status.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bec_la_operand_bridge;

    localparam int OPW = 163;
    localparam int CW  = 82;
    localparam int NR  = 7;
    localparam int TO  = 16;
    localparam int TOT = NR * OPW;

    localparam logic [7:0] NOP = 8'h00, WR = 8'hA1, ST = 8'hA2, RD = 8'hA3, AB = 8'hAF;

    logic           clk         = 1'b0;
    logic           rst_n       = 1'b0;
    logic [127:0]   la_data_in  = '0;
    logic [127:0]   la_oenb     = '0;
    logic [127:0]   la_data_out;
    logic           core_start;
    logic           core_abort;
    logic [TOT-1:0] core_ops;
    logic           core_done   = 1'b0;
    logic [TOT-1:0] core_result = '0;

    always #5 clk = ~clk;

    bec_la_operand_bridge #(
        .OP_WIDTH    (OPW),
        .CHUNK_W     (CW),
        .NUM_REGS    (NR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .la_data_in  (la_data_in),
        .la_oenb     (la_oenb),
        .la_data_out (la_data_out),
        .core_start  (core_start),
        .core_abort  (core_abort),
        .core_ops    (core_ops),
        .core_done   (core_done),
        .core_result (core_result)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [127:0] q_exp[$];

    // Behavioural model
    logic [OPW-1:0] m_regs [NR];
    logic [3:0]     m_st;
    logic           m_seq;
    logic           m_err;
    logic           m_toflag;
    logic [95:0]    m_data;
    int             m_cnt;

    task automatic chk(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        m_st = 4'h1; m_seq = 1'b0; m_err = 1'b0; m_toflag = 1'b0; m_data = '0; m_cnt = 0;
    endtask

    task automatic chk_ops(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_r%0d", tag, i), core_ops[i*OPW +: OPW], m_regs[i]);
    endtask

    // kind: 0 = hold seq (no command), 1 = new command, 2 = command masked by la_oenb
    task automatic cycle(input int kind, input logic [7:0] op, input int r, input int c,
                         input logic [95:0] pl, input bit done, input logic [TOT-1:0] res);
        logic        pin_seq;
        bit          acc, legal, abort_acc, exp_start, exp_abort, rng;
        logic [3:0]  st0;
        logic [245:0] ext;
        logic [127:0] exp_word;
        @(negedge clk);
        pin_seq     = (kind == 0) ? m_seq : ~m_seq;
        la_oenb     = (kind == 2) ? (128'b1 << 20) : '0;
        la_data_in  = {pl, op, r[4:0], c[2:0], pin_seq, 15'h0};
        core_done   = done;
        core_result = res;

        st0 = m_st; acc = (kind == 1); legal = 1'b0;
        exp_start = 1'b0; exp_abort = 1'b0; abort_acc = 1'b0;
        rng = (r < NR) && (c < 2);
        if (acc) begin
            m_seq = pin_seq;
            case (op)
                NOP: legal = 1'b1;
                WR: begin
                    legal = rng && (st0 != 4'h9);
                    if (legal) begin
                        ext = {83'b0, m_regs[r]};
                        ext[c*CW +: CW] = pl[CW-1:0];
                        m_regs[r] = ext[OPW-1:0];
                        m_st = 4'h2;
                    end
                end
                ST: begin
                    legal = (st0 == 4'h2) || (st0 == 4'hC);
                    if (legal) begin m_st = 4'h9; m_cnt = 0; exp_start = 1'b1; end
                end
                RD: begin
                    legal = rng && ((st0 == 4'h1) || (st0 == 4'hC));
                    if (legal) begin
                        ext = {83'b0, m_regs[r]};
                        m_data = {14'b0, ext[c*CW +: CW]};
                    end
                end
                AB: begin
                    legal = 1'b1; abort_acc = 1'b1;
                    exp_abort = (st0 == 4'h9);
                    m_st = 4'h1;
                end
                default: legal = 1'b0;
            endcase
            m_err = !legal;
            m_toflag = 1'b0;
        end
        if ((st0 == 4'h9) && !abort_acc) begin
            if (done) begin
                for (int i = 0; i < NR; i++) m_regs[i] = res[i*OPW +: OPW];
                m_st = 4'hC;
            end else begin
`ifdef BEC_BRIDGE_TIMEOUT_EN
                m_cnt++;
                if (m_cnt == TO) begin
                    m_st = 4'h1; m_err = 1'b1; m_toflag = 1'b1; exp_abort = 1'b1;
                end
`endif
            end
        end
        exp_word = {(m_toflag ? 4'hF : m_st), m_seq, m_err, 26'b0, m_data};
        q_exp.push_back(exp_word);

        @(posedge clk); #1;
        chk("la_data_out", la_data_out, q_exp.pop_front());
        chk("core_start", core_start, exp_start);
        chk("core_abort", core_abort, exp_abort);
        chk_ops("ops");
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) cycle(0, NOP, 0, 0, '0, 1'b0, '0);
    endtask

    task automatic cmd(input logic [7:0] op, input int r, input int c, input logic [95:0] pl);
        cycle(1, op, r, c, pl, 1'b0, '0);
    endtask

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    logic [TOT-1:0] res_a, res_b;

    initial begin
        m_reset();
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_la_out", la_data_out, '0);
        chk("rst_start", core_start, 1'b0);
        chk("rst_abort", core_abort, 1'b0);
        chk_ops("rst_ops");
        @(negedge clk);
        rst_n = 1'b1;
        tick(1);                                   // status becomes IDLE

        // First write: status LOAD, seq echo 1, err 0
        cmd(WR, 0, 0, 96'h1);
        // Held seq with changed payload must not re-execute
        for (int k = 0; k < 20; k++) cycle(0, WR, 0, 0, 96'hFF, 1'b0, '0);

        // Illegal commands: bad reg, bad chunk, unknown opcode; then NOP clears err
        cmd(WR, 7, 0, 96'h123);
        cmd(WR, 0, 2, 96'h456);
        cmd(8'h55, 0, 0, '0);
        cmd(NOP, 0, 0, '0);
        // Command masked by la_oenb is ignored
        cycle(2, WR, 1, 0, 96'hDEAD, 1'b0, '0);
        tick(1);

        // Load all 14 chunks (payload bits above CHUNK_W are dropped)
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < 2; c++) cmd(WR, r, c, rnd96());
        cmd(ST, 0, 0, '0);
        cmd(WR, 3, 0, 96'h7);                      // illegal while BUSY
        cmd(ST, 0, 0, '0);                         // illegal while BUSY
        tick(8);
        res_a = '0;
        res_a[0 +: OPW]     = 163'h5;
        res_a[OPW +: OPW]   = {3'b101, rnd96(), rnd96()};
        res_a[6*OPW +: OPW] = '1;
        cycle(0, NOP, 0, 0, '0, 1'b1, res_a);      // core_done -> READY
        cmd(RD, 0, 0, '0);                         // data 0x5
        cmd(RD, 6, 1, '0);                         // short last chunk, zero-extended
        cmd(RD, 1, 1, '0);
        cmd(RD, 7, 0, '0);                         // illegal, data kept
        res_b = '1;
        cycle(0, NOP, 0, 0, '0, 1'b1, res_b);      // done outside BUSY ignored
        core_done = 1'b0;

        // Chaining: partial overwrite, restart, then abort racing core_done
        cmd(WR, 2, 0, rnd96());
        cmd(ST, 0, 0, '0);
        tick(3);
        cycle(1, AB, 0, 0, '0, 1'b1, res_b);
        tick(1);
        cmd(AB, 0, 0, '0);                         // abort in IDLE: no pulse
        cmd(RD, 2, 0, '0);                         // read legal in IDLE

        // Async reset in the middle of BUSY
        cmd(ST, 0, 0, '0);                         // illegal in IDLE
        cmd(WR, 4, 1, rnd96());
        cmd(ST, 0, 0, '0);
        @(negedge clk);
        #2;
        rst_n = 1'b0; la_data_in = '0; la_oenb = '0; core_done = 1'b0;
        #1;
        m_reset();
        chk("midrst_la_out", la_data_out, '0);
        chk("midrst_start", core_start, 1'b0);
        chk("midrst_abort", core_abort, 1'b0);
        chk_ops("midrst_ops");
        @(negedge clk);
        rst_n = 1'b1;
        tick(2);

`ifdef BEC_BRIDGE_TIMEOUT_EN
        // Watchdog: no core_done for TO cycles -> IDLE, status F, err, abort pulse
        cmd(WR, 0, 0, 96'h9);
        cmd(ST, 0, 0, '0);
        tick(TO + 2);
        cmd(NOP, 0, 0, '0);                        // clears status F and err
`endif
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bec_la_operand_bridge
`default_nettype wire
